// File: rtl/pwm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_pkg : shared FSM encoding and counter helpers for pwm_medidor. Rev 1.0
// ---------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    MIDE_ALTO = 2'd1,
    MIDE_BAJO = 2'd2
  } estado_t;

  // Saturation value of a w-bit tick counter (2**w-1).
  function automatic longint unsigned cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sync_flancos.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_sync_flancos : SYNC-stage synchroniser plus rising/falling strobes. Rev 1.0
// ---------------------------------------------------------------------------
module pwm_sync_flancos #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic sube,
  output logic baja,
  output logic nivel
);

  logic [SYNC-1:0] cadena;
  logic            s_prev;
  logic            s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cadena <= '0;
      s_prev <= 1'b0;
    end else begin
      cadena <= {cadena[SYNC-2:0], pwm_in};
      s_prev <= cadena[SYNC-1];
    end
  end

  assign s     = cadena[SYNC-1];
  assign nivel = s;
  assign sube  = s & ~s_prev;
  assign baja  = ~s & s_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_medidor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_medidor : measures PWM high time and period in prescaled ticks. Rev 1.0
// ---------------------------------------------------------------------------
module pwm_medidor
  import pwm_pkg::*;
#(
  parameter int W    = 16,
  parameter int P    = 0,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [W-1:0] alto,
  output logic [W-1:0] periodo,
  output logic         valido,
  output logic         sin_senal,
  output logic         nivel
);

  localparam logic [W-1:0] CNT_MAX = W'(cnt_max(W));

  logic         tick;
  logic         sube;
  logic         baja;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  logic [W-1:0] alto_tmp;
  estado_t      estado;
  estado_t      estado_next;
  logic         reinicia;
  logic         captura_alto;
  logic         reporta;
  logic         timeout;
  logic         toma_timeout;

  generate
    if (P == 0) begin : g_sin_presc
      assign tick = 1'b1;
    end else begin : g_presc
      logic [P-1:0] div;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) div <= '0;
        else       div <= div + 1'b1;
      end
      assign tick = &div;
    end
  endgenerate

  pwm_sync_flancos #(.SYNC(SYNC)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .sube   (sube),
    .baja   (baja),
    .nivel  (nivel)
  );

  assign timeout = (cnt == CNT_MAX) && tick;

  // An edge that the current state acts on takes priority over the timeout.
  always_comb begin
    estado_next  = estado;
    reinicia     = 1'b0;
    captura_alto = 1'b0;
    reporta      = 1'b0;
    toma_timeout = 1'b0;
    case (estado)
      ESPERA: begin
        if (sube) begin
          estado_next = MIDE_ALTO;
          reinicia    = 1'b1;
        end else if (timeout) begin
          toma_timeout = 1'b1;
        end
      end
      MIDE_ALTO: begin
        if (baja) begin
          estado_next  = MIDE_BAJO;
          captura_alto = 1'b1;
        end else if (timeout) begin
          toma_timeout = 1'b1;
        end
      end
      MIDE_BAJO: begin
        if (sube) begin
          estado_next = MIDE_ALTO;
          reporta     = 1'b1;
          reinicia    = 1'b1;
        end else if (timeout) begin
          toma_timeout = 1'b1;
        end
      end
      default: estado_next = ESPERA;
    endcase
    if (toma_timeout) estado_next = ESPERA;
  end

  always_comb begin
    cnt_next = cnt;
    if (toma_timeout)                 cnt_next = '0;
    else if (reinicia)                cnt_next = tick ? W'(1) : '0;
    else if (tick && cnt != CNT_MAX)  cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= ESPERA;
      cnt    <= '0;
    end else begin
      estado <= estado_next;
      cnt    <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alto_tmp  <= '0;
      alto      <= '0;
      periodo   <= '0;
      valido    <= 1'b0;
      sin_senal <= 1'b0;
    end else begin
      valido <= reporta;
      if (captura_alto) alto_tmp <= cnt;
      if (reporta) begin
        alto    <= alto_tmp;
        periodo <= cnt;
      end
      if (toma_timeout) sin_senal <= 1'b1;
      else if (reporta) sin_senal <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_medidor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_medidor : directed bench for pwm_medidor across W/P variants. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pwm_medidor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

  logic [15:0] alto_a, periodo_a, alto_b, periodo_b;
  logic [7:0]  alto_c, periodo_c;
  logic val_a, sin_a, niv_a, val_b, sin_b, niv_b, val_c, sin_c, niv_c;

  int n_chk = 0;
  int n_pass = 0;
  int consec = 0;
  int qa_alto[$], qa_per[$], qb_alto[$], qb_per[$], qc_alto[$], qc_per[$];

  always #5 clk = ~clk;

  pwm_medidor #(.W(16), .P(0), .SYNC(2)) dut_a (
    .clk(clk), .reset(reset), .pwm_in(pa), .alto(alto_a), .periodo(periodo_a),
    .valido(val_a), .sin_senal(sin_a), .nivel(niv_a));
  pwm_medidor #(.W(16), .P(2), .SYNC(2)) dut_b (
    .clk(clk), .reset(reset), .pwm_in(pb), .alto(alto_b), .periodo(periodo_b),
    .valido(val_b), .sin_senal(sin_b), .nivel(niv_b));
  pwm_medidor #(.W(8), .P(0), .SYNC(2)) dut_c (
    .clk(clk), .reset(reset), .pwm_in(pc), .alto(alto_c), .periodo(periodo_c),
    .valido(val_c), .sin_senal(sin_c), .nivel(niv_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one pwm line to v and hold for n clocks; called on a falling edge.
  task automatic put(input int sel, input bit v, input int n);
    case (sel)
      0: pa = v;
      1: pb = v;
      default: pc = v;
    endcase
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    qa_alto.delete(); qa_per.delete();
    qb_alto.delete(); qb_per.delete();
    qc_alto.delete(); qc_per.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_q();
  endtask

  initial begin : collector
    bit pva, pvb, pvc;
    pva = 0; pvb = 0; pvc = 0;
    forever begin
      @(negedge clk);
      if (val_a) begin qa_alto.push_back(int'(alto_a)); qa_per.push_back(int'(periodo_a)); end
      if (val_b) begin qb_alto.push_back(int'(alto_b)); qb_per.push_back(int'(periodo_b)); end
      if (val_c) begin qc_alto.push_back(int'(alto_c)); qc_per.push_back(int'(periodo_c)); end
      if ((val_a && pva) || (val_b && pvb) || (val_c && pvc)) consec++;
      pva = val_a; pvb = val_b; pvc = val_c;
    end
  end

  initial begin : main
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_alto_a", alto_a, 0);
    check("rst_periodo_a", periodo_a, 0);
    check("rst_valido_a", val_a, 0);
    check("rst_sin_a", sin_a, 0);
    check("rst_nivel_a", niv_a, 0);
    check("rst_periodo_c", periodo_c, 0);

    // 16-clk period at 75 % duty: five rising edges give four reports.
    do_reset();
    put(0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      put(0, 1, 12);
      put(0, 0, 4);
    end
    put(0, 1, 12);
    put(0, 0, 8);
    check("t1_nrep", qa_alto.size(), 4);
    for (int i = 0; i < qa_alto.size(); i++) begin
      check($sformatf("t1_alto%0d", i), qa_alto[i], 12);
      check($sformatf("t1_per%0d", i), qa_per[i], 16);
    end
    check("t1_sin", sin_a, 0);

    // P=2: 64-clk period, 16 clks high -> 4 / 16 ticks.
    do_reset();
    put(1, 0, 5);
    for (int i = 0; i < 3; i++) begin
      put(1, 1, 16);
      put(1, 0, 48);
    end
    put(1, 1, 16);
    put(1, 0, 8);
    check("t2_nrep", qb_alto.size(), 3);
    for (int i = 0; i < qb_alto.size(); i++) begin
      check($sformatf("t2_alto%0d", i), qb_alto[i], 4);
      check($sformatf("t2_per%0d", i), qb_per[i], 16);
    end

    // W=8, held low from reset: timeout after 255 ticks, no report.
    do_reset();
    repeat (200) @(negedge clk);
    check("t4_sin_early", sin_c, 0);
    repeat (100) @(negedge clk);
    check("t4_sin", sin_c, 1);
    check("t4_nivel", niv_c, 0);
    check("t4_nrep", qc_alto.size(), 0);

    // Restart, then hold high after a rising edge.
    put(2, 1, 8);
    put(2, 0, 8);
    check("t3_sin_sticky", sin_c, 1);
    put(2, 1, 8);
    put(2, 0, 8);
    put(2, 1, 8);
    check("t3_sin_clr", sin_c, 0);
    check("t3_nrep", qc_alto.size(), 2);
    repeat (300) @(negedge clk);
    check("t3_sin_hi", sin_c, 1);
    check("t3_nivel_hi", niv_c, 1);
    check("t3_alto_hold", alto_c, 8);
    check("t3_per_hold", periodo_c, 16);
    check("t3_nrep_hold", qc_alto.size(), 2);
    put(2, 0, 8);
    put(2, 1, 8);
    put(2, 0, 8);
    check("t3_sin_after_1st", sin_c, 1);
    put(2, 1, 8);
    put(2, 0, 8);
    check("t3_sin_resume", sin_c, 0);
    check("t3_nrep_resume", qc_alto.size(), 3);
    check("t3_per_resume", periodo_c, 16);

    // Reset in MIDE_BAJO: immediate clear, two more rising edges needed.
    do_reset();
    put(0, 0, 2);
    put(0, 1, 12);
    put(0, 0, 4);
    put(0, 1, 12);
    put(0, 0, 4);
    check("t5_pre_alto", alto_a, 12);
    #2;
    reset = 1'b1;
    #1;
    check("t5_alto", alto_a, 0);
    check("t5_periodo", periodo_a, 0);
    check("t5_valido", val_a, 0);
    check("t5_sin", sin_a, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_q();
    put(0, 0, 2);
    put(0, 1, 12);
    put(0, 0, 4);
    check("t5_nrep_1st", qa_alto.size(), 0);
    put(0, 1, 12);
    put(0, 0, 8);
    check("t5_nrep_2nd", qa_alto.size(), 1);
    check("t5_alto2", alto_a, 12);
    check("t5_per2", periodo_a, 16);

    // 1-clk glitch inside low phase becomes its own period.
    do_reset();
    put(0, 0, 2);
    put(0, 1, 4);
    put(0, 0, 6);
    put(0, 1, 1);
    put(0, 0, 5);
    put(0, 1, 4);
    put(0, 0, 8);
    check("t6_nrep", qa_alto.size(), 2);
    if (qa_alto.size() == 2) begin
      check("t6_alto0", qa_alto[0], 4);
      check("t6_per0", qa_per[0], 10);
      check("t6_alto1", qa_alto[1], 1);
      check("t6_per1", qa_per[1], 6);
    end

    check("valido_consec", consec, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
